// File: rtl/aqua_pkg.sv
// Shared constants for the water-level control path: class codes and
// the level-controller state encoding.
package aqua_pkg;

  localparam logic [2:0] CL_MUITO_BAIXO = 3'd0;
  localparam logic [2:0] CL_BAIXO       = 3'd1;
  localparam logic [2:0] CL_NORMAL      = 3'd2;
  localparam logic [2:0] CL_ALTO        = 3'd3;
  localparam logic [2:0] CL_MUITO_ALTO  = 3'd4;

  localparam logic [1:0] ST_OCIOSO  = 2'd0;
  localparam logic [1:0] ST_FECHADA = 2'd1;
  localparam logic [1:0] ST_ABERTA  = 2'd2;
  localparam logic [1:0] ST_FALHA   = 2'd3;

  // Codes 5..7 are reserved and behave like a discarded measurement.
  function automatic logic classe_valida(input logic [2:0] classe);
    return classe <= CL_MUITO_ALTO;
  endfunction

endpackage

// File: rtl/confirmador_classe.sv
// Consecutive-class filter: tracks the last valid class and how many times
// in a row it was seen; flags the event on which the run reaches N_CONFIRMA.
module confirmador_classe
  import aqua_pkg::*;
#(
  parameter int N_CONFIRMA = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       evento,
  input  logic [2:0] classe,
  input  logic       limpa,
  output logic       confirmado,
  output logic [2:0] classe_conf
);

  localparam int CW = $clog2(N_CONFIRMA + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_CONFIRMA);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [2:0]    ultima_reg, ultima_next;
  logic [CW-1:0] conf_cnt_reg, conf_cnt_next;

  always_comb begin
    ultima_next   = ultima_reg;
    conf_cnt_next = conf_cnt_reg;
    confirmado    = 1'b0;
    if (limpa) begin
      ultima_next   = CL_NORMAL;
      conf_cnt_next = '0;
    end else if (evento) begin
      if (classe == ultima_reg) begin
        // Once saturated the run stays confirmed silently.
        if (conf_cnt_reg != CNT_MAX) begin
          conf_cnt_next = conf_cnt_reg + CNT_ONE;
          confirmado    = (conf_cnt_next == CNT_MAX);
        end
      end else begin
        ultima_next   = classe;
        conf_cnt_next = CNT_ONE;
        confirmado    = (CNT_MAX == CNT_ONE);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ultima_reg   <= CL_NORMAL;
      conf_cnt_reg <= '0;
    end else begin
      ultima_reg   <= ultima_next;
      conf_cnt_reg <= conf_cnt_next;
    end
  end

  assign classe_conf = classe;

endmodule

// File: rtl/controle_valvula_nivel.sv
// Fill-valve controller: acts on confirmed level classes, drives buzzer pulses
// and latches into FALHA on repeated discards or an over-long fill.
module controle_valvula_nivel
  import aqua_pkg::*;
#(
  parameter int N_CONFIRMA   = 3,
  parameter int M_DESCARTES  = 4,
  parameter int T_ENCHIMENTO = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fim_classificacao,
  input  logic [2:0] medida_classificacao,
  input  logic       descartar_medida,
  input  logic       limpa_falha,
  output logic       abre_valvula,
  output logic       liga_buzzer_alta,
  output logic       liga_buzzer_baixa,
  output logic       desliga_buzzers,
  output logic       zera_vlv,
  output logic       falha,
  output logic [1:0] db_estado
);

  localparam logic [3:0] M_MAX = 4'(M_DESCARTES);
  localparam logic [7:0] T_MAX = 8'(T_ENCHIMENTO);

  logic [1:0] estado_reg, estado_next;
  logic [3:0] desc_cnt_reg, desc_next;
  logic [7:0] fill_cnt_reg, fill_next;
  logic       fill_para_reg, fill_para_next;
  logic [2:0] prev_conf_reg, prev_next;
  logic       alarme_reg, alarme_next;
  logic       abre_reg, alta_reg, baixa_reg, desliga_reg, zera_reg, falha_reg;
  logic       alta_next, baixa_next, desliga_next, zera_next;
  logic       evento_valido, evento_desc, sai_falha, entra_falha;
  logic       confirmado;
  logic [2:0] classe_conf;

  assign sai_falha     = (estado_reg == ST_FALHA) && limpa_falha;
  assign evento_valido = fim_classificacao && (estado_reg != ST_FALHA) &&
                         !descartar_medida && classe_valida(medida_classificacao);
  assign evento_desc   = fim_classificacao && (estado_reg != ST_FALHA) &&
                         (descartar_medida || !classe_valida(medida_classificacao));

  confirmador_classe #(.N_CONFIRMA(N_CONFIRMA)) u_confirmador (
    .clock       (clock),
    .reset       (reset),
    .evento      (evento_valido),
    .classe      (medida_classificacao),
    .limpa       (sai_falha),
    .confirmado  (confirmado),
    .classe_conf (classe_conf)
  );

  always_comb begin
    estado_next    = estado_reg;
    desc_next      = desc_cnt_reg;
    fill_next      = fill_cnt_reg;
    fill_para_next = fill_para_reg;
    prev_next      = prev_conf_reg;
    alarme_next    = alarme_reg;
    alta_next      = 1'b0;
    baixa_next     = 1'b0;
    desliga_next   = 1'b0;
    zera_next      = 1'b0;
    entra_falha    = 1'b0;

    if (evento_desc) begin
      if (desc_cnt_reg != M_MAX) desc_next = desc_cnt_reg + 4'd1;
      if (desc_next == M_MAX) entra_falha = 1'b1;
    end else if (evento_valido) begin
      desc_next = '0;
    end

    // Fill timer counts every event while open until a NORMAL+ is confirmed.
    if ((estado_reg == ST_ABERTA) && (evento_valido || evento_desc) && !fill_para_reg) begin
      if (fill_cnt_reg != T_MAX) fill_next = fill_cnt_reg + 8'd1;
      if (fill_next == T_MAX) entra_falha = 1'b1;
    end

    if (sai_falha) begin
      estado_next    = ST_OCIOSO;
      zera_next      = 1'b1;
      desliga_next   = 1'b1;
      desc_next      = '0;
      fill_next      = '0;
      fill_para_next = 1'b0;
      prev_next      = CL_NORMAL;
      alarme_next    = 1'b0;
    end else if (entra_falha) begin
      estado_next = ST_FALHA;
      alta_next   = 1'b1;
      baixa_next  = 1'b1;
    end else if (confirmado) begin
      if ((classe_conf == CL_MUITO_BAIXO) && (prev_conf_reg != CL_MUITO_BAIXO)) baixa_next = 1'b1;
      if ((classe_conf == CL_MUITO_ALTO) && (prev_conf_reg != CL_MUITO_ALTO)) alta_next = 1'b1;
      if ((classe_conf == CL_MUITO_BAIXO) || (classe_conf == CL_MUITO_ALTO)) begin
        alarme_next = 1'b1;
      end else if (alarme_reg) begin
        desliga_next = 1'b1;
        alarme_next  = 1'b0;
      end
      prev_next = classe_conf;

      case (estado_reg)
        ST_OCIOSO, ST_FECHADA: begin
          if (classe_conf <= CL_BAIXO) begin
            estado_next    = ST_ABERTA;
            fill_next      = '0;
            fill_para_next = 1'b0;
          end else if (estado_reg == ST_OCIOSO) begin
            estado_next = ST_FECHADA;
          end
        end
        ST_ABERTA: begin
          // NORMAL keeps the valve open but ends the fill timeout window.
          if (classe_conf >= CL_NORMAL) fill_para_next = 1'b1;
          if (classe_conf >= CL_ALTO) estado_next = ST_FECHADA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg    <= ST_OCIOSO;
      desc_cnt_reg  <= '0;
      fill_cnt_reg  <= '0;
      fill_para_reg <= 1'b0;
      prev_conf_reg <= CL_NORMAL;
      alarme_reg    <= 1'b0;
      abre_reg      <= 1'b0;
      alta_reg      <= 1'b0;
      baixa_reg     <= 1'b0;
      desliga_reg   <= 1'b0;
      zera_reg      <= 1'b0;
      falha_reg     <= 1'b0;
    end else begin
      estado_reg    <= estado_next;
      desc_cnt_reg  <= desc_next;
      fill_cnt_reg  <= fill_next;
      fill_para_reg <= fill_para_next;
      prev_conf_reg <= prev_next;
      alarme_reg    <= alarme_next;
      abre_reg      <= (estado_next == ST_ABERTA);
      alta_reg      <= alta_next;
      baixa_reg     <= baixa_next;
      desliga_reg   <= desliga_next;
      zera_reg      <= zera_next;
      falha_reg     <= (estado_next == ST_FALHA);
    end
  end

  assign abre_valvula      = abre_reg;
  assign liga_buzzer_alta  = alta_reg;
  assign liga_buzzer_baixa = baixa_reg;
  assign desliga_buzzers   = desliga_reg;
  assign zera_vlv          = zera_reg;
  assign falha             = falha_reg;
  assign db_estado         = estado_reg;

endmodule
